// File: rtl/if_fetch_stage_pkg.sv
// Shared types for the instruction-fetch stage and its IF/ID latch.
// Holds the fetch FSM encoding, the bubble instruction and the {pc, inst} pair.
package if_fetch_stage_pkg;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        FETCH = 2'd1,
        HOLD  = 2'd2,
        DRAIN = 2'd3
    } fetch_state_t;

    localparam logic [31:0] DEF_NOP_INST = 32'h0000_0013;

    typedef struct packed {
        logic [31:0] pc;
        logic [31:0] inst;
    } pc_inst_t;

    localparam int PC_INST_W = $bits(pc_inst_t);

endpackage

// File: rtl/if_fetch_stage_if_id_latch.sv
// IF/ID pipeline latch: {valid, pc, inst} with load, hold and flush.
// A flush turns the held slot into a bubble but keeps its pc.
module if_id_latch
    import if_fetch_stage_pkg::*;
#(
    parameter logic [31:0] NOP_INST = DEF_NOP_INST
) (
    input  logic     clk,
    input  logic     rst,
    input  logic     ce,
    input  logic     load,
    input  logic     flush,
    input  pc_inst_t d,
    output logic     valid,
    output pc_inst_t q
);

    always_ff @(posedge clk) begin
        if (!rst) begin
            valid  <= 1'b0;
            q.pc   <= '0;
            q.inst <= NOP_INST;
        end else if (ce) begin
            if (flush) begin
                valid  <= 1'b0;
                q.inst <= NOP_INST;
            end else if (load) begin
                valid <= 1'b1;
                q     <= d;
            end
        end
    end

endmodule

// File: rtl/if_fetch_stage.sv
// Instruction-fetch stage: req/ack fetch, skid on ID stall, flush drain.
// Optional fetch watchdog enabled with `define FETCH_TIMEOUT_EN.
module if_fetch_stage
    import if_fetch_stage_pkg::*;
#(
    parameter logic [31:0] NOP_INST       = DEF_NOP_INST,
    parameter int          TIMEOUT_CYCLES = 255
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        CE,
    input  logic [31:0] pc_in,
    output logic        pc_stall,
    output logic        imem_req,
    output logic [31:0] imem_addr,
    input  logic        imem_ack,
    input  logic [31:0] imem_rdata,
    input  logic        id_stall,
    input  logic        flush,
    output logic        ifid_valid,
    output logic [31:0] ifid_pc,
    output logic [31:0] ifid_inst,
    output logic        fetch_err
);

    if (TIMEOUT_CYCLES < 1) begin : g_bad_timeout
        $error("TIMEOUT_CYCLES must be positive");
    end

    fetch_state_t state_q, state_d;
    pc_inst_t     skid_q;
    pc_inst_t     ifid_q;
    pc_inst_t     ifid_d;
    logic [31:0]  req_pc_q;
    logic         ifid_load;
    logic         ifid_flush;
    logic         skid_load;
    logic         req_pc_load;
    logic         accept;
    logic         tmo_hit;

    assign accept = imem_ack & (~id_stall | ~ifid_valid);

`ifdef FETCH_TIMEOUT_EN
    localparam int CNT_W =
        ($clog2(TIMEOUT_CYCLES + 1) > 8) ? $clog2(TIMEOUT_CYCLES + 1) : 8;

    logic [CNT_W-1:0] tmo_cnt_q;
    logic             waiting;
    logic             err_q;

    // A cycle counts only while a request is actually on the bus.
    assign waiting = imem_req & ~imem_ack &
                     ((state_q == FETCH) | (state_q == DRAIN));
    assign tmo_hit = waiting & ~flush &
                     (tmo_cnt_q == CNT_W'(TIMEOUT_CYCLES - 1));

    always_ff @(posedge clk) begin
        if (!rst) begin
            tmo_cnt_q <= '0;
            err_q     <= 1'b0;
        end else if (CE) begin
            if (imem_ack | flush | tmo_hit)
                tmo_cnt_q <= '0;
            else if (waiting)
                tmo_cnt_q <= tmo_cnt_q + 1'b1;
            if (tmo_hit)
                err_q <= 1'b1;
        end
    end

    assign fetch_err = err_q;
`else
    assign tmo_hit   = 1'b0;
    assign fetch_err = 1'b0;
`endif

    always_comb begin
        state_d     = state_q;
        imem_req    = 1'b0;
        imem_addr   = pc_in;
        pc_stall    = 1'b1;
        ifid_load   = 1'b0;
        ifid_flush  = 1'b0;
        skid_load   = 1'b0;
        req_pc_load = 1'b0;
        ifid_d      = '{pc: pc_in, inst: imem_rdata};

        unique case (state_q)
            IDLE: begin
                state_d = FETCH;
                if (flush) begin
                    pc_stall   = 1'b0;
                    ifid_flush = 1'b1;
                end
            end
            FETCH: begin
                imem_req = 1'b1;
                if (flush) begin
                    pc_stall   = 1'b0;
                    ifid_flush = 1'b1;
                    if (!imem_ack) begin
                        req_pc_load = 1'b1;
                        state_d     = DRAIN;
                    end
                end else if (accept) begin
                    ifid_load = 1'b1;
                    pc_stall  = 1'b0;
                end else if (imem_ack) begin
                    skid_load = 1'b1;
                    pc_stall  = 1'b0;
                    state_d   = HOLD;
                end else if (tmo_hit) begin
                    ifid_d    = '{pc: pc_in, inst: NOP_INST};
                    ifid_load = 1'b1;
                    pc_stall  = 1'b0;
                end
            end
            HOLD: begin
                ifid_d = skid_q;
                if (flush) begin
                    pc_stall   = 1'b0;
                    ifid_flush = 1'b1;
                    state_d    = FETCH;
                end else if (!id_stall) begin
                    ifid_load = 1'b1;
                    state_d   = FETCH;
                end
            end
            DRAIN: begin
                imem_req  = 1'b1;
                imem_addr = req_pc_q;
                if (flush) begin
                    pc_stall   = 1'b0;
                    ifid_flush = 1'b1;
                end else if (imem_ack | tmo_hit) begin
                    state_d = FETCH;
                end
            end
            default: state_d = IDLE;
        endcase

        // Frozen stage: no new request; PC may still take a redirect.
        if (!CE) begin
            imem_req = 1'b0;
            pc_stall = ~(flush & ((state_q == FETCH) | (state_q == IDLE)));
        end
    end

    always_ff @(posedge clk) begin
        if (!rst) begin
            state_q  <= IDLE;
            skid_q   <= '0;
            req_pc_q <= '0;
        end else if (CE) begin
            state_q <= state_d;
            if (skid_load)
                skid_q <= '{pc: pc_in, inst: imem_rdata};
            if (req_pc_load)
                req_pc_q <= pc_in;
        end
    end

    if_id_latch #(
        .NOP_INST(NOP_INST)
    ) u_if_id_latch (
        .clk  (clk),
        .rst  (rst),
        .ce   (CE),
        .load (ifid_load),
        .flush(ifid_flush),
        .d    (ifid_d),
        .valid(ifid_valid),
        .q    (ifid_q)
    );

    assign ifid_pc   = ifid_q.pc;
    assign ifid_inst = ifid_q.inst;

endmodule

// File: tb/tb_if_fetch_stage.sv
// Directed self-checking bench for if_fetch_stage.
// Inputs change 1ns after posedge; outputs are sampled 1ns later.
module tb_if_fetch_stage;

    localparam logic [31:0] NOP = 32'h0000_0013;
    localparam logic [31:0] MSK = 32'hA5A5_0000;

    logic        clk = 1'b0;
    logic        rst;
    logic        CE;
    logic [31:0] pc_in;
    logic        pc_stall;
    logic        imem_req;
    logic [31:0] imem_addr;
    logic        imem_ack;
    logic [31:0] imem_rdata;
    logic        id_stall;
    logic        flush;
    logic        ifid_valid;
    logic [31:0] ifid_pc;
    logic [31:0] ifid_inst;
    logic        fetch_err;

    int n_chk  = 0;
    int n_pass = 0;

    always #5 clk = ~clk;

    if_fetch_stage dut (
        .clk       (clk),
        .rst       (rst),
        .CE        (CE),
        .pc_in     (pc_in),
        .pc_stall  (pc_stall),
        .imem_req  (imem_req),
        .imem_addr (imem_addr),
        .imem_ack  (imem_ack),
        .imem_rdata(imem_rdata),
        .id_stall  (id_stall),
        .flush     (flush),
        .ifid_valid(ifid_valid),
        .ifid_pc   (ifid_pc),
        .ifid_inst (ifid_inst),
        .fetch_err (fetch_err)
    );

    task automatic check(input string tag, input logic [31:0] got,
                         input logic [31:0] exp);
        n_chk++;
        if (got === exp) n_pass++;
        else $display("FAIL %s: got %h expected %h", tag, got, exp);
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic settle();
        #1;
    endtask

    initial begin
        rst = 1'b0; CE = 1'b1; pc_in = '0; imem_ack = 1'b0;
        imem_rdata = '0; id_stall = 1'b0; flush = 1'b0;
        tick(); tick();
        check("rst_valid", 32'(ifid_valid), 32'd0);
        check("rst_pc", ifid_pc, 32'd0);
        check("rst_inst", ifid_inst, NOP);
        check("rst_err", 32'(fetch_err), 32'd0);
        check("idle_req", 32'(imem_req), 32'd0);
        check("idle_stall", 32'(pc_stall), 32'd1);

        rst = 1'b1;
        tick();

        // zero-wait stream
        imem_ack = 1'b1;
        for (int i = 0; i < 3; i++) begin
            pc_in = 32'(i * 4);
            imem_rdata = pc_in ^ MSK;
            settle();
            check("zw_stall", 32'(pc_stall), 32'd0);
            check("zw_addr", imem_addr, pc_in);
            tick();
            check("zw_valid", 32'(ifid_valid), 32'd1);
            check("zw_pc", ifid_pc, 32'(i * 4));
            check("zw_inst", ifid_inst, 32'(i * 4) ^ MSK);
        end

        // three wait states at 0x10
        imem_ack = 1'b0; pc_in = 32'h10; imem_rdata = 32'h10 ^ MSK;
        for (int i = 0; i < 3; i++) begin
            settle();
            check("ws_stall", 32'(pc_stall), 32'd1);
            check("ws_addr", imem_addr, 32'h10);
            tick();
            check("ws_hold_pc", ifid_pc, 32'h8);
        end
        imem_ack = 1'b1;
        settle();
        check("ws_adv", 32'(pc_stall), 32'd0);
        tick();
        check("ws_pc", ifid_pc, 32'h10);
        check("ws_inst", ifid_inst, 32'h10 ^ MSK);

        // back-pressure into HOLD
        id_stall = 1'b1; pc_in = 32'h20; imem_rdata = 32'h20 ^ MSK;
        settle();
        check("bp_adv", 32'(pc_stall), 32'd0);
        tick();
        imem_ack = 1'b0; pc_in = 32'h24;
        settle();
        check("bp_pc_hold", ifid_pc, 32'h10);
        check("hold_req", 32'(imem_req), 32'd0);
        check("hold_stall", 32'(pc_stall), 32'd1);
        tick();
        check("bp_pc_hold2", ifid_pc, 32'h10);
        id_stall = 1'b0;
        tick();
        check("bp_pc", ifid_pc, 32'h20);
        check("bp_inst", ifid_inst, 32'h20 ^ MSK);

        // flush with request outstanding at 0x30
        pc_in = 32'h30;
        settle();
        check("fl_addr", imem_addr, 32'h30);
        tick();
        flush = 1'b1;
        settle();
        check("fl_adv", 32'(pc_stall), 32'd0);
        tick();
        flush = 1'b0; pc_in = 32'h100;
        settle();
        check("fl_valid", 32'(ifid_valid), 32'd0);
        check("fl_inst", ifid_inst, NOP);
        check("dr_addr", imem_addr, 32'h30);
        check("dr_req", 32'(imem_req), 32'd1);
        check("dr_stall", 32'(pc_stall), 32'd1);
        tick();
        check("dr_addr2", imem_addr, 32'h30);
        imem_ack = 1'b1; imem_rdata = 32'hDEAD_BEEF;
        settle();
        check("dr_addr3", imem_addr, 32'h30);
        tick();
        check("dr_drop", 32'(ifid_valid), 32'd0);
        imem_rdata = 32'h100 ^ MSK;
        settle();
        check("rf_addr", imem_addr, 32'h100);
        tick();
        check("rf_pc", ifid_pc, 32'h100);
        check("rf_valid", 32'(ifid_valid), 32'd1);

        // flush + ack + id_stall: no HOLD
        id_stall = 1'b1; flush = 1'b1; pc_in = 32'h104;
        settle();
        check("fa_adv", 32'(pc_stall), 32'd0);
        tick();
        flush = 1'b0; id_stall = 1'b0; imem_ack = 1'b0; pc_in = 32'h200;
        settle();
        check("fa_valid", 32'(ifid_valid), 32'd0);
        check("fa_inst", ifid_inst, NOP);
        check("fa_req", 32'(imem_req), 32'd1);
        check("fa_stall", 32'(pc_stall), 32'd1);

        // clock enable low freezes
        CE = 1'b0; imem_ack = 1'b1; imem_rdata = 32'h200 ^ MSK;
        settle();
        check("ce_req", 32'(imem_req), 32'd0);
        check("ce_stall", 32'(pc_stall), 32'd1);
        tick();
        check("ce_valid", 32'(ifid_valid), 32'd0);
        CE = 1'b1;
        tick();
        check("ce_load", ifid_pc, 32'h200);

        // reset while in HOLD
        pc_in = 32'h204; id_stall = 1'b1; imem_rdata = 32'h204 ^ MSK;
        tick();
        check("rh_hold_req", 32'(imem_req), 32'd0);
        rst = 1'b0;
        tick();
        check("rh_valid", 32'(ifid_valid), 32'd0);
        check("rh_pc", ifid_pc, 32'd0);
        check("rh_inst", ifid_inst, NOP);
        check("rh_req", 32'(imem_req), 32'd0);
        check("rh_stall", 32'(pc_stall), 32'd1);
        rst = 1'b1; imem_ack = 1'b0; id_stall = 1'b0; pc_in = 32'h300;
        tick();
        check("rh_fetch", 32'(imem_req), 32'd1);

`ifdef FETCH_TIMEOUT_EN
        begin
            int n;
            n = 0;
            while (!fetch_err && n < 400) begin
                tick();
                n++;
            end
            check("to_cycles", 32'(n), 32'd255);
            check("to_err", 32'(fetch_err), 32'd1);
            check("to_valid", 32'(ifid_valid), 32'd1);
            check("to_inst", ifid_inst, NOP);
            check("to_pc", ifid_pc, 32'h300);
        end
`else
        for (int i = 0; i < 300; i++) tick();
        check("nt_err", 32'(fetch_err), 32'd0);
        check("nt_stall", 32'(pc_stall), 32'd1);
        check("nt_addr", imem_addr, 32'h300);
`endif

        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end

endmodule

// File: doc/if_fetch_stage.md
Name: if_fetch_stage

Overview:
- Instruction-fetch stage directly downstream of the 32-bit PC register.
- Issues the register's current PC to instruction memory over a req/ack handshake.
- Captures the returned word into the IF/ID pipeline latch.
- Drives the PC register's stall input so the PC advances only when a fetched instruction is accepted. Handles ID back-pressure and branch flush.

Parameters:
- NOP_INST, 32'h00000013: bubble word placed in ifid_inst on reset or flush.
- TIMEOUT_CYCLES, 255: fetch watchdog limit; used only with FETCH_TIMEOUT_EN.

Ports:
- clk  in  1  single clock; all state updates on its rising edge.
- rst  in  1  synchronous, active-low reset (rst==0 at posedge resets).
- CE  in  1  clock enable; CE==0 freezes all state. rst has priority over CE.
- pc_in  in  32  current PC from the PC register Q.
- pc_stall  out  1  to the PC register's stall input; 1 = hold PC.
- imem_req  out  1  fetch request.
- imem_addr  out  32  fetch address.
- imem_ack  in  1  memory response valid; may assert in the same cycle as imem_req.
- imem_rdata  in  32  instruction word, valid with imem_ack.
- id_stall  in  1  ID stage cannot accept a new instruction.
- flush  in  1  branch/jump redirect; PC register loads the target this cycle.
- ifid_valid  out  1  IF/ID latch holds a real instruction.
- ifid_pc  out  32  PC of the latched instruction.
- ifid_inst  out  32  latched instruction.
- fetch_err  out  1  sticky timeout flag; tied 0 without FETCH_TIMEOUT_EN.

Behaviour:
- States: IDLE, FETCH, HOLD, DRAIN. Reset → IDLE.
- Reset values: ifid_valid=0, ifid_pc=0, ifid_inst=NOP_INST, skid registers cleared, fetch_err=0.
- IDLE: imem_req=0, pc_stall=1. Next cycle → FETCH, giving one cycle of PC settle after reset.
- FETCH:
  - imem_req=1, imem_addr=pc_in.
  - accept = imem_ack & (~id_stall | ~ifid_valid).
  - On accept: ifid ← {1, pc_in, imem_rdata}, pc_stall=0, stay in FETCH. Zero-wait memory therefore sustains 1 instruction/cycle.
  - imem_ack with ID stalled: word goes to skid registers {pc, inst}, pc_stall=0 (PC advances), → HOLD.
  - No ack: pc_stall=1. pc_in, and so imem_addr, stays stable until ack.
- HOLD:
  - imem_req=0, pc_stall=1.
  - When id_stall==0: ifid ← skid, → FETCH.
- DRAIN:
  - imem_req=1, imem_addr=req_pc (latched address of the abandoned request), pc_stall=1.
  - On imem_ack: data is discarded, → FETCH.
- Flush (highest priority after rst and CE):
  - Every state, that cycle: pc_stall=0 so the PC loads the target; ifid_valid←0, ifid_inst←NOP_INST. Flush overrides id_stall.
  - FETCH with no ack: latch req_pc←pc_in, → DRAIN.
  - FETCH with ack: data discarded, stay in FETCH.
  - HOLD: skid discarded, → FETCH.
  - DRAIN: stay in DRAIN.
- id_stall with no flush: IF/ID latch holds its value.
- The handshake address never changes while imem_req=1 and imem_ack=0.
- CE==0: outputs stay at their registered values. imem_req is forced 0, and pc_stall is forced 1 unless a flush arrives in FETCH/IDLE.

Optional Feature:
- Macro: FETCH_TIMEOUT_EN.
- With it:
  - An 8+ bit counter increments each FETCH/DRAIN cycle with imem_req=1 and no ack. It clears on ack or flush.
  - When the count reaches TIMEOUT_CYCLES, fetch_err is set (sticky until reset).
  - In that same cycle the stage fakes an ack with NOP_INST: it loads ifid with valid=1 and inst=NOP_INST, and the PC advances.
- Without it: no counter is generated, fetch_err=0, and the stage waits indefinitely.

Decomposition:
- Shared package holds:
  - state encoding typedef (IDLE/FETCH/HOLD/DRAIN, 2 bits)
  - NOP_INST default
  - a struct/width constant for the {pc, inst} pair used by both the IF/ID latch and the skid registers
- One natural sub-module: if_id_latch, a {valid, pc, inst} register with load, hold and flush inputs.

Test Plan:
- Zero-wait fetch: rst low 2 cycles, then ack tied 1 with rdata=pc^32'hA5A5_0000, pc_in=0,4,8. Required: ifid_pc sequence 0,4,8 on consecutive cycles, ifid_valid=1, pc_stall=0 each cycle.
- Wait states: ack delayed 3 cycles at pc_in=0x10. Required: pc_stall=1 and imem_addr=0x10 for 3 cycles; ifid_inst captured on the 4th; PC advances once.
- Back-pressure: id_stall=1 while ifid_valid=1 and ack returns for 0x20. Required: → HOLD, ifid unchanged. After id_stall drops, ifid_pc=0x20 the next cycle.
- Flush mid-wait: request at 0x30 outstanding, flush with pc_in→0x100. Required: ifid_valid=0, DRAIN keeps imem_addr=0x30 until ack. The 0x30 data is dropped; next ifid_pc=0x100.
- Flush with simultaneous ack and id_stall: required ifid_valid=0, ifid_inst=NOP_INST, no HOLD entry.
- Reset mid-HOLD, plus timeout: rst low in HOLD → IDLE with all reset values. Under FETCH_TIMEOUT_EN, ack never returns → fetch_err=1 after 255 cycles and ifid_inst=NOP_INST.
